// File: rtl/muldiv_pkg.sv
// Shared constants for the M-extension multiply/divide controller:
// funct3 opcodes, datapath widths and the controller state encoding.
package muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, trial-subtract
// the divisor and keep the difference when it does not borrow.
module div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nx,
  output logic [XLEN-1:0] quot_nx
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  always_comb begin
    shifted = {rem[XLEN-1:0], quot[XLEN-1]};
    // rem[XLEN] set means the true shifted value exceeds 2^(XLEN+1), so it always fits;
    // the modular difference is still exact because the new remainder is below the divisor.
    fits    = rem[XLEN] | (shifted >= {1'b0, divisor});
    trial   = shifted - {1'b0, divisor};
    rem_nx  = fits ? trial : shifted;
    quot_nx = {quot[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_controller.sv
// EX-stage sequencer for RV32 M-extension ops: 2-cycle registered multiply,
// 34-cycle restoring divide, 1-cycle fast path for divide-by-zero and overflow.
module muldiv_controller
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output state_e          dbg_state
);

  // Handshake: start_i is held by EX while the instruction sits there; stall_o holds
  // the pipeline until DONE, where done_o pulses with result_o and stall_o drops.

  state_e                state_q, state_d;
  logic [2:0]            op_q;
  logic [XLEN:0]         a_q, b_q;
  logic [XLEN:0]         rem_q;
  logic [XLEN-1:0]       quot_q, divisor_q;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic                  neg_quot_q, neg_rem_q;

  logic                  signed_div, div_zero, div_ovf;
  logic [XLEN-1:0]       fast_result, abs_rs1, abs_rs2;
  logic                  a_sign, b_sign;
  logic [2*XLEN-1:0]     product;
  logic [XLEN-1:0]       mul_result, fix_quot, fix_rem, fix_result;
  logic [XLEN:0]         rem_nx;
  logic [XLEN-1:0]       quot_nx;

  assign signed_div  = ~op_i[0];
  assign div_zero    = (rs2_i == '0);
  assign div_ovf     = signed_div && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign fast_result = div_zero ? (op_i[1] ? rs1_i : '1)
                                : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign abs_rs1     = (signed_div && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign abs_rs2     = (signed_div && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  assign a_sign = (op_i == OP_MULH || op_i == OP_MULHSU) && rs1_i[XLEN-1];
  assign b_sign = (op_i == OP_MULH) && rs2_i[XLEN-1];

  // Only the low 2*XLEN bits of the 33x33 signed product are ever selected.
  assign product    = {{(XLEN-1){a_q[XLEN]}}, a_q} * {{(XLEN-1){b_q[XLEN]}}, b_q};
  assign mul_result = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  assign fix_quot   = neg_quot_q ? -quot_q : quot_q;
  assign fix_rem    = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign fix_result = op_q[1] ? fix_rem : fix_quot;

  div_step u_div_step (
    .rem     (rem_q),
    .quot    (quot_q),
    .divisor (divisor_q),
    .rem_nx  (rem_nx),
    .quot_nx (quot_nx)
  );

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          if (!op_i[2])                state_d = MUL;
          else if (div_zero || div_ovf) state_d = DONE;
          else                          state_d = DIV;
        end
      end
      MUL: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DIV: begin
        stall_o = 1'b1;
        if (cnt_q == DIV_CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      done_o     <= 1'b0;
      result_o   <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      if (!flush_i) begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              op_q <= op_i;
              if (!op_i[2]) begin
                a_q <= {a_sign, rs1_i};
                b_q <= {b_sign, rs2_i};
              end else if (div_zero || div_ovf) begin
                result_o <= fast_result;
                done_o   <= 1'b1;
              end else begin
                rem_q      <= '0;
                quot_q     <= abs_rs1;
                divisor_q  <= abs_rs2;
                neg_quot_q <= signed_div && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                neg_rem_q  <= signed_div && rs1_i[XLEN-1];
                cnt_q      <= DIV_CNT_W'(XLEN);
              end
            end
          end
          MUL: begin
            result_o <= mul_result;
            done_o   <= 1'b1;
          end
          DIV: begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q - DIV_CNT_W'(1);
          end
          FIX: begin
            result_o <= fix_result;
            done_o   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Bench for muldiv_controller: fixed vector table, randomized ops against an
// arithmetic reference model, and flush / reset / start-with-flush sequences.
module tb_muldiv_controller;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = '0;
  logic [31:0] exp_q[$];

  muldiv_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic from the RISC-V M-extension rules.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // driver: start one op in the next cycle, hold start_i until done_o, scramble
  // operands after the start cycle, and report latency and stall cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    @(posedge clk); #1;
    check("done_low_before_start", {31'b0, done_o}, 32'h0);
    check("result_hold", result_o, last_result);
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    lat = 0; stalls = 0; res = '0;
    #1;
    if (stall_o) stalls++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = n;
        res = result_o;
        check("stall_low_at_done", {31'b0, stall_o}, 32'h0);
        break;
      end
      if (stall_o) stalls++;
      op_i = 3'($urandom_range(0, 7)); rs1_i = $urandom; rs2_i = $urandom;
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none required=done_o within 100 cycles");
    end
    start_i = 1'b0;
  endtask

  task automatic run_and_score(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, stalls;
    exp_q.push_back(exp);
    run_op(op, a, b, res, lat, stalls);
    check({name, "_result"}, res, exp_q.pop_front());
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_cycles"}, stalls, exp_lat);
    last_result = exp;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          pulses;

    vecs[0]  = '{"mul_7x6",      OP_MUL,    32'd7,          32'd6,          32'd42,         2};
    vecs[1]  = '{"mulh_m1",      OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  2};
    vecs[2]  = '{"mulhu_m1",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  2};
    vecs[3]  = '{"mulhsu_m1",    OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  2};
    vecs[4]  = '{"div_m7_2",     OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[5]  = '{"rem_m7_2",     OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[6]  = '{"divu_m7_2",    OP_DIVU,   32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  34};
    vecs[7]  = '{"divu_by0",     OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{"rem_by0",      OP_REM,    32'd5,          32'd0,          32'd5,          1};
    vecs[9]  = '{"div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[10] = '{"rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vecs[11] = '{"remu_100_7",   OP_REMU,   32'd100,        32'd7,          32'd2,          34};
    vecs[12] = '{"mul_wrap",     OP_MUL,    32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  2};
    vecs[13] = '{"div_7_m2",     OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_done", {31'b0, done_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    check("reset_stall", {31'b0, stall_o}, 32'h0);

    // table vectors, issued back to back
    foreach (vecs[i])
      run_and_score(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // flush mid-divide at cycle 10
    @(posedge clk); #1;
    op_i = OP_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_pre_stall", {31'b0, stall_o}, 32'h1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    check("flush_state", 32'(dbg_state), 32'(IDLE));
    check("flush_stall", {31'b0, stall_o}, 32'h0);
    check("flush_result_hold", result_o, last_result);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done_o) pulses++;
    end
    check("flush_no_done", pulses, 0);
    run_and_score("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 2);

    // start together with flush is no start
    @(posedge clk); #1;
    op_i = OP_DIV; rs1_i = 32'd9; rs2_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
    #1;
    check("start_flush_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    check("start_flush_state", 32'(dbg_state), 32'(IDLE));
    check("start_flush_done", {31'b0, done_o}, 32'h0);
    start_i = 1'b0; flush_i = 1'b0;

    // reset mid-divide at cycle 5
    @(posedge clk); #1;
    op_i = OP_DIVU; rs1_i = 32'd77; rs2_i = 32'd5; start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("midreset_state", 32'(dbg_state), 32'(IDLE));
    check("midreset_done", {31'b0, done_o}, 32'h0);
    check("midreset_result", result_o, 32'h0);
    check("midreset_stall", {31'b0, stall_o}, 32'h0);
    reset = 1'b0;
    last_result = '0;

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_and_score($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b,
                    model_result(r_op, r_a, r_b), model_latency(r_op, r_a, r_b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
